// File: rtl/dram_ctrl_if.sv
// dram_ctrl_if: request/response bundle between a DRAM requester and dram_ctrl.
// The master drives the request; the slave returns read data and the completion pulse.
interface dram_ctrl_if;
  logic [31:0] dramAddress;
  logic [31:0] dramWriteData;
  logic        dramWriteEnable;
  logic        dramReadEnable;
  logic [31:0] dramReadData;
  logic        dramValid;

  modport master (
    output dramAddress,
    output dramWriteData,
    output dramWriteEnable,
    output dramReadEnable,
    input  dramReadData,
    input  dramValid
  );

  modport slave (
    input  dramAddress,
    input  dramWriteData,
    input  dramWriteEnable,
    input  dramReadEnable,
    output dramReadData,
    output dramValid
  );
endinterface

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-outstanding word DRAM model with a fixed access latency.
// Define DRAM_ERR_EN to add the sticky dramError protocol-error output.
module dram_ctrl #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  dram_ctrl_if.slave bus
`ifdef DRAM_ERR_EN
  ,
  output logic       dramError
`endif
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    WAITLOW
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 wr_q, wr_d;
  logic                 valid_q, valid_d;
  logic                 mem_we;
  logic                 req;

  logic [31:0] mem [DEPTH];

  assign req = bus.dramWriteEnable | bus.dramReadEnable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = bus.dramAddress[ADDR_BITS+1:2];
          wdata_d = bus.dramWriteData;
          wr_d    = bus.dramWriteEnable;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          if (wr_q) mem_we = 1'b1;
          else rdata_d = mem[idx_q];
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // A request already dropped in the valid cycle skips the wait.
      RESP: state_d = req ? WAITLOW : IDLE;
      WAITLOW: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Store contents survive reset; only a committed write touches them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign bus.dramReadData = rdata_q;
  assign bus.dramValid    = valid_q;

`ifdef DRAM_ERR_EN
  logic err_q, err_d;
  logic bad_addr;

  assign bad_addr = (|(bus.dramAddress >> (ADDR_BITS + 2)))
                  | (|bus.dramAddress[1:0]);

  assign err_d = err_q
               | ((state_q == IDLE) && req
                  && ((bus.dramWriteEnable && bus.dramReadEnable)
                      || bad_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else err_q <= err_d;
  end

  assign dramError = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^bus.dramAddress;
`endif
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: randomized scoreboard bench for dram_ctrl against a word-array model.
// Define DRAM_ERR_EN to also track the sticky error flag.
module tb_dram_ctrl;
  localparam int AB      = 12;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 1 << AB;
  localparam logic [31:0] IDX_MASK = 32'((DEPTH - 1) << 2);

  typedef struct {
    int          due;
    logic [31:0] rdata;
`ifdef DRAM_ERR_EN
    bit          err;
`endif
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [int];
  logic [31:0] exp_rd = '0;
  bit          exp_err = 1'b0;
  int          pool[$];

  dram_ctrl_if bus();

`ifdef DRAM_ERR_EN
  logic dram_err;
`endif

  dram_ctrl #(
    .ADDR_BITS(AB),
    .LATENCY  (LATENCY),
    .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DRAM_ERR_EN
    ,
    .dramError(dram_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.dramValid !== 1'b0 || bus.dramReadData !== 32'h0) begin
        errors++;
        $display("FAIL reset_out valid=%b rdata=%h required 0/00000000",
                 bus.dramValid, bus.dramReadData);
      end
`ifdef DRAM_ERR_EN
      checks++;
      if (dram_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_err got=%b required 0", dram_err);
      end
`endif
    end else if (bus.dramValid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at edge %0d, none required", edge_n);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.due != edge_n || bus.dramReadData !== mon_e.rdata) begin
          errors++;
          $display("FAIL response edge=%0d rdata=%h required edge=%0d rdata=%h",
                   edge_n, bus.dramReadData, mon_e.due, mon_e.rdata);
        end
`ifdef DRAM_ERR_EN
        checks++;
        if (dram_err !== mon_e.err) begin
          errors++;
          $display("FAIL error_flag got=%b required %b", dram_err, mon_e.err);
        end
`endif
      end
    end else if (sb.size() != 0 && edge_n > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_valid at edge %0d required by edge %0d",
               edge_n, sb[0].due);
      void'(sb.pop_front());
    end
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  // Called #1 after an edge with the DUT able to accept at the next edge.
  task automatic do_op(input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] data, input int hold,
                       input bit scramble);
    exp_t e;
    bit   seen;
    int   idx;
    idx = idx_of(addr);
    bus.dramAddress     = addr;
    bus.dramWriteData   = data;
    bus.dramWriteEnable = we;
    bus.dramReadEnable  = re;
    if (we) model_mem[idx] = data;
    else exp_rd = model_mem[idx];
`ifdef DRAM_ERR_EN
    if ((we && re) || (addr & ~IDX_MASK) != 32'h0) exp_err = 1'b1;
    e.err = exp_err;
`endif
    e.due   = edge_n + 1 + LATENCY;
    e.rdata = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    if (scramble) begin
      bus.dramAddress   = $urandom;
      bus.dramWriteData = $urandom;
    end
    seen = 1'b0;
    for (int k = 0; k < LATENCY + 4 && !seen; k++) begin
      @(posedge clk); #1;
      seen = bus.dramValid;
    end
    repeat (hold) begin @(posedge clk); #1; end
    bus.dramWriteEnable = 1'b0;
    bus.dramReadEnable  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic enter_reset();
    reset = 1'b0;
    sb.delete();
    exp_rd  = '0;
    exp_err = 1'b0;
  endtask

  task automatic hold_reset();
    repeat (2) begin
      bus.dramWriteEnable = 1'($urandom);
      bus.dramReadEnable  = 1'($urandom);
      bus.dramAddress     = $urandom;
      @(posedge clk); #1;
    end
    bus.dramWriteEnable = 1'b0;
    bus.dramReadEnable  = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] prior;
    int          op;
    int          idx;
    bus.dramAddress     = '0;
    bus.dramWriteData   = '0;
    bus.dramWriteEnable = 1'b0;
    bus.dramReadEnable  = 1'b0;
    #1;
    enter_reset();
    hold_reset();

    pool.push_back(32'h20 >> 2);
    pool.push_back(32'h40 >> 2);
    pool.push_back(32'h10 >> 2);
    pool.push_back(32'h08 >> 2);
    pool.push_back(0);
    repeat (10) pool.push_back($urandom_range(0, DEPTH - 1));
    foreach (pool[i]) do_op(1, 0, 32'(pool[i]) << 2, $urandom, 0, 0);

    do_op(1, 0, 32'h20, 32'hDEADBEEF, 0, 0);
    do_op(0, 1, 32'h20, 32'h0, 0, 0);
    do_op(0, 1, 32'h20, 32'h0, 10, 0);
    do_op(0, 1, 32'h20, 32'h0, 0, 0);
    do_op(1, 0, 32'h40, 32'h0BADF00D, 0, 0);
    bus.dramAddress = 32'h20;
    bus.dramReadEnable = 1'b1;
    model_mem[idx_of(32'h20)] = model_mem[idx_of(32'h20)];
    do_op(0, 1, 32'h20, 32'h0, 0, 1);
    do_op(1, 1, 32'h8, 32'hA5A5A5A5, 0, 0);
    do_op(0, 1, 32'h8, 32'h0, 0, 0);

    prior = model_mem[idx_of(32'h10)];
    bus.dramAddress     = 32'h10;
    bus.dramWriteData   = 32'h12345678;
    bus.dramWriteEnable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enter_reset();
    hold_reset();
    do_op(0, 1, 32'h10, 32'h0, 0, 0);
    checks++;
    if (model_mem[idx_of(32'h10)] !== prior) begin
      errors++;
      $display("FAIL model_prior got=%h required %h",
               model_mem[idx_of(32'h10)], prior);
    end
    do_op(1, 0, 32'h00004002, 32'h5A5A0001, 0, 0);
    do_op(0, 1, 32'h0, 32'h0, 0, 0);

    repeat (80) begin
      op  = $urandom_range(0, 3);
      idx = pool[$urandom_range(0, pool.size() - 1)];
      if (op >= 2 && $urandom_range(0, 4) == 0) begin
        idx = $urandom_range(0, DEPTH - 1);
        pool.push_back(idx);
      end
      a = 32'(idx) << 2;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & ~IDX_MASK);
      do_op(op >= 2, op != 2, a, $urandom, $urandom_range(0, 3),
            1'($urandom));
    end

    repeat (LATENCY + 4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
